sort_stream_arb: RTL

Packet-level round-robin arbiter that shares one sort input engine (stream sink on snk_clock) among NUM_CH independent input streams. It locks a granted channel for a whole sop..eop packet and forwards it beat-by-beat to the engine sink. It enforces MAX_LENGTH by truncating oversized packets and flushing their tail, discards orphan beats, and reports the channel index of the packet in flight for downstream tagging. Sits directly in front of the sort input interface; the engine's ready provides all backpressure.

---
 rtl/sort_stream_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sort_stream_arb.sv
// sort_stream_arb: packet-level round-robin arbiter feeding one sort engine sink.
// A granted channel is locked for a whole sop..eop packet and passed through
// combinationally. Oversized packets are cut at MAX_LENGTH and their tail is
// flushed. Non-sop beats seen while idle are dropped.
module sort_stream_arb #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_LENGTH = 256,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                             snk_clock,
  input  logic                             snk_reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     in_data,
  input  logic [NUM_CH-1:0]                in_sop,
  input  logic [NUM_CH-1:0]                in_eop,
  input  logic [NUM_CH-1:0]                in_valid,
  output logic [NUM_CH-1:0]                in_ready,
  output logic [DATA_WIDTH-1:0]            eng_data,
  output logic                             eng_sop,
  output logic                             eng_eop,
  output logic                             eng_valid,
  input  logic                             eng_ready,
  output logic [$clog2(NUM_CH)-1:0]        cur_ch,
  output logic                             cur_ch_valid,
  output logic                             err_trunc,
  output logic                             err_orphan,
  output logic [15:0]                      pkt_count
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(MAX_LENGTH) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LENGTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_PASS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CH_W-1:0]   last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic              grant_load;
  logic              pkt_inc;
  logic              trunc_d;
  logic              orphan_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] orphan;
  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  logic [CH_W-1:0]   rr_idx;

  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid;
  logic                  g_sop;
  logic                  g_eop;
  logic [NUM_CH-1:0]     g_onehot;
  logic                  cnt_at_last;

  assign req          = in_valid & in_sop;
  assign orphan       = in_valid & ~in_sop;
  assign cur_ch_valid = (state != ST_ARB);
  assign cnt_at_last  = (cnt == CNT_LAST);

  // Select the granted channel's stream signals
  always_comb begin
    g_data   = '0;
    g_valid  = 1'b0;
    g_sop    = 1'b0;
    g_eop    = 1'b0;
    g_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_W'(i)) begin
        g_data      = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        g_valid     = in_valid[i];
        g_sop       = in_sop[i];
        g_eop       = in_eop[i];
        g_onehot[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting one past the last grant, wrapping at NUM_CH-1
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = last_grant;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rr_idx = (rr_idx == CH_LAST) ? '0 : rr_idx + CH_W'(1);
      if (!win_found && req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  // Next-state and stream-side outputs
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    grant_load = 1'b0;
    pkt_inc    = 1'b0;
    trunc_d    = 1'b0;
    orphan_d   = 1'b0;
    in_ready   = '0;
    eng_data   = g_data;
    eng_valid  = 1'b0;
    eng_sop    = 1'b0;
    eng_eop    = 1'b0;

    case (state)
      ST_ARB: begin
        in_ready = orphan;
        orphan_d = |orphan;
        if (win_found) begin
          grant_load = 1'b1;
          cnt_d      = '0;
          state_d    = ST_PASS;
        end
      end
      ST_PASS: begin
        eng_valid = g_valid;
        eng_sop   = g_sop & (cnt == '0);
        eng_eop   = g_eop | cnt_at_last;
        in_ready  = eng_ready ? g_onehot : '0;
        if (g_valid && eng_ready) begin
          if (g_eop) begin
            pkt_inc = 1'b1;
            cnt_d   = '0;
            state_d = ST_ARB;
          end else if (cnt_at_last) begin
            pkt_inc = 1'b1;
            trunc_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        in_ready = g_onehot;
        if (g_valid && g_eop) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase

    // Nothing is accepted or offered while reset is held
    if (snk_reset) begin
      in_ready  = '0;
      eng_valid = 1'b0;
    end
  end

  // State register
  always_ff @(posedge snk_clock or posedge snk_reset) begin
    if (snk_reset) begin
      state <= ST_ARB;
    end else begin
      state <= state_d;
    end
  end

  // Grant, beat counter, packet counter and error pulse registers
  always_ff @(posedge snk_clock or posedge snk_reset) begin
    if (snk_reset) begin
      last_grant <= CH_LAST;
      cur_ch     <= '0;
      cnt        <= '0;
      pkt_count  <= '0;
      err_trunc  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (grant_load) begin
        last_grant <= win_idx;
        cur_ch     <= win_idx;
      end
      cnt        <= cnt_d;
      err_trunc  <= trunc_d;
      err_orphan <= orphan_d;
      if (pkt_inc && (pkt_count != 16'hFFFF)) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule
